// File: rtl/exec_ctrl_if.sv
// Run/step controller bundle: board inputs and decoder halt in, clock-generator
// enable and status out.
interface exec_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             run_sw;
    logic             step_btn;
    logic             halt_req;
    logic             ena;
    logic             running;
    logic             halted;
    logic [2:0]       phase;
    logic [CNT_W-1:0] instr_count;

    modport master (
        output run_sw, step_btn, halt_req,
        input  ena, running, halted, phase, instr_count
    );

    modport slave (
        input  run_sw, step_btn, halt_req,
        output ena, running, halted, phase, instr_count
    );
endinterface

// File: rtl/exec_ctrl.sv
// Run/step execution controller feeding the 8-phase clock generator's enable.
// Stops only on instruction boundaries by mirroring the generator phase.
module exec_ctrl_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk_in,
    input  logic rst,
    input  logic raw,
    output logic level
);
    localparam logic [15:0] CMAX = 16'(DEBOUNCE_CYCLES - 1);

    logic        s0, s1;
    logic [15:0] cnt;

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            s0    <= 1'b0;
            s1    <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
        end else begin
            s0 <= raw;
            s1 <= s0;
            // counter only runs while the synchronised input disagrees
            if (s1 == level) begin
                cnt <= '0;
            end else if (cnt == CMAX) begin
                level <= s1;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 16'd1;
            end
        end
    end
endmodule

module exec_ctrl #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic         clk_in,
    input  logic         rst,
    exec_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, RUN, STEP, HALT} state_t;

    state_t           state, state_nxt;
    logic             ena_q, ena_nxt;
    logic             halt_pend;
    logic [2:0]       phase_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       raw_in, db;
    logic             step_q, step_pulse, run_db;
    logic             boundary, halt_eff;

    assign raw_in = {bus.step_btn, bus.run_sw};

    for (genvar i = 0; i < 2; i++) begin : g_db
        exec_ctrl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk_in (clk_in),
            .rst    (rst),
            .raw    (raw_in[i]),
            .level  (db[i])
        );
    end

    assign run_db     = db[0];
    assign step_pulse = db[1] & ~step_q;
    assign boundary   = ena_q && (phase_q == 3'd7);
    // a halt decoded on the boundary edge itself acts as if already latched
    assign halt_eff   = halt_pend | bus.halt_req;

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            ena_q     <= 1'b0;
            halt_pend <= 1'b0;
            phase_q   <= '0;
            cnt_q     <= '0;
            step_q    <= 1'b0;
        end else begin
            state  <= state_nxt;
            ena_q  <= ena_nxt;
            step_q <= db[1];
            if (ena_q)
                phase_q <= phase_q + 3'd1;
            if (boundary)
                cnt_q <= cnt_q + 1'b1;
            if (state_nxt == IDLE || state_nxt == HALT)
                halt_pend <= 1'b0;
            else if (ena_q && bus.halt_req)
                halt_pend <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        ena_nxt   = ena_q;
        case (state)
            IDLE: begin
                ena_nxt = 1'b0;
                if (run_db) begin
                    state_nxt = RUN;
                    ena_nxt   = 1'b1;
                end else if (step_pulse) begin
                    state_nxt = STEP;
                    ena_nxt   = 1'b1;
                end
            end
            RUN: begin
                ena_nxt = 1'b1;
                if (boundary) begin
                    if (halt_eff) begin
                        state_nxt = HALT;
                        ena_nxt   = 1'b0;
                    end else if (!run_db) begin
                        state_nxt = IDLE;
                        ena_nxt   = 1'b0;
                    end
                end
            end
            STEP: begin
                ena_nxt = 1'b1;
                if (boundary) begin
                    if (halt_eff) begin
                        state_nxt = HALT;
                        ena_nxt   = 1'b0;
                    end else if (run_db) begin
                        state_nxt = RUN;
                    end else begin
                        state_nxt = IDLE;
                        ena_nxt   = 1'b0;
                    end
                end
            end
            default: begin
                state_nxt = HALT;
                ena_nxt   = 1'b0;
            end
        endcase
    end

    always_comb begin
        bus.running     = (state == RUN) || (state == STEP);
        bus.halted      = (state == HALT);
        bus.ena         = ena_q;
        bus.phase       = phase_q;
        bus.instr_count = cnt_q;
    end
endmodule

// File: doc/exec_ctrl.md
Name: exec_ctrl

Overview:
- Run/step execution controller directly upstream of the 8-phase processor clock generator. It generates that generator's `ena` input.
- Debounces the board run switch and step button.
- Mirrors the generator's phase count so that execution always stops on an instruction boundary (phase 0).
- Latches a halt request from the instruction decoder and counts completed instructions.

Parameters:
- DEBOUNCE_CYCLES, 50000: consecutive clk_in cycles an input must stay stable, at its new synchronised value, before the debounced value changes. Legal range 2..65535.
- CNT_W, 16: width of the instruction counter.

Ports:
- clk_in  input  1  system clock; same clock that drives the clock generator.
- rst  input  1  asynchronous, active-low reset.
- run_sw  input  1  raw run switch level; 1 = free-run.
- step_btn  input  1  raw single-step push button; 1 = pressed.
- halt_req  input  1  HLT opcode decoded; level, sampled only while ena=1.
- ena  output  1  registered enable to the clock generator.
- running  output  1  1 while in RUN or STEP.
- halted  output  1  1 while in HALT.
- phase  output  3  mirror of the clock generator state: 0 = s1 … 7 = s8.
- instr_count  output  CNT_W  number of completed instructions, modulo 2^CNT_W.

Behaviour:
- Reset (rst=0, asynchronous):
  - ena=0, running=0, halted=0, phase=0, instr_count=0.
  - FSM goes to IDLE; halt_pend=0.
  - Synchronisers, debounced values and debounce counters all go to 0.
  - Reset mid-instruction aborts immediately. The clock generator shares rst, so both return to phase 0 together.
- Input conditioning, applied separately to run_sw and step_btn:
  - Two-flop synchroniser.
  - Debounce counter, cleared whenever the synchronised value equals the debounced value.
  - The debounced value flips when the counter reaches DEBOUNCE_CYCLES-1 while the two still differ.
  - step_pulse is one clk_in cycle wide, on the rising edge of the debounced step value.
  - Falling edges generate no pulse.
- Phase mirror:
  - On every clk_in edge where ena=1, phase advances by 1, wrapping 7→0.
  - With ena=0, phase holds.
  - Boundary edge = an edge with ena=1 and phase=7.
  - On each boundary edge instr_count increments by 1, wrapping from all-ones to 0.
- Halt latch:
  - halt_pend is set on any edge with ena=1 and halt_req=1.
  - It is cleared on entry to HALT or IDLE.
- FSM states: IDLE, RUN, STEP, HALT.
  - IDLE:
    - run_db=1 → RUN, ena<=1.
    - Otherwise step_pulse=1 → STEP, ena<=1.
    - run_db has priority over step_pulse.
  - RUN:
    - ena stays 1 and transitions are evaluated only on boundary edges.
    - halt_pend → HALT, ena<=0.
    - Else run_db=0 → IDLE, ena<=0.
    - Else stay in RUN.
    - run_sw dropping mid-instruction finishes the current instruction.
  - STEP:
    - Transitions are evaluated only on boundary edges.
    - halt_pend → HALT, ena<=0.
    - Else run_db=1 → RUN, ena stays 1.
    - Else → IDLE, ena<=0.
    - step_pulse in STEP or RUN is ignored and is not queued.
  - HALT:
    - ena=0, halted=1.
    - Inputs are ignored; the only exit is rst.
- running=1 in RUN and in STEP.
- ena is a pure register with no combinational path from the inputs.
  - ena drops only on a boundary edge, so the generator is always left in s1 with phase=0.
- A single step spans exactly 8 ena=1 cycles.
- A halt_req seen on the boundary edge itself takes effect at that same edge, as if halt_pend were already set.

Test Plan (DEBOUNCE_CYCLES=4 in all scenarios):
- Reset/idle: hold rst=0, then release with all inputs 0 for 20 cycles → ena=0, phase=0, instr_count=0, running=0, halted=0 throughout.
- Debounce: step_btn glitch high for 3 cycles → no ena. Step_btn held high for 10 cycles → ena rises 7 cycles after step_btn rises, then stays 1 for exactly 8 cycles. Afterwards phase=0, instr_count=1, state IDLE. Keeping the button held produces no second step.
- Free-run: run_sw=1 for 100 cycles after debounce latency, then 0 → ena continuous. ena falls only on an edge where phase was 7, and instr_count equals the number of boundary edges seen.
- Halt: in RUN, pulse halt_req for 1 cycle at phase 3 → the instruction completes through phase 7, then ena=0 and halted=1. Subsequent run_sw or step_btn activity has no effect until rst.
- Step→run: start a step, raise run_sw mid-step → at the boundary ena stays 1 and the FSM enters RUN, with no phase gap.
- Wrap and reset mid-op: with CNT_W=4, run 17 instructions → instr_count=1. Assert rst at phase 5 → all outputs return to their reset values immediately.
